// File: rtl/systolic_skew_feeder_pkg.sv
// Shared constants, FSM encoding and lane helpers for the systolic feeder
// and the PE cluster bench.
package systolic_skew_feeder_pkg;

    localparam int LANES  = 8;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        STREAM    = 2'd1,
        FLUSH     = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    // Bit offset of lane `lane` inside a packed LANES*w vector.
    function automatic int lane_lo(input int lane, input int w = DATA_W);
        return lane * w;
    endfunction

endpackage

// File: rtl/systolic_skew_feeder_skew.sv
// Fixed-depth shift register; one instance per lane delays that lane's
// {done, wgt, act} bundle so operands meet on the array's diagonal wavefront.
module skew_delay_line #(
    parameter int DEPTH = 1,
    parameter int W     = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < DEPTH; j++) begin
                stage[j] <= '0;
            end
        end else begin
            stage[0] <= din;
            for (int j = 1; j < DEPTH; j++) begin
                stage[j] <= stage[j-1];
            end
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Transmit side of the 8x8 systolic cluster: accepts K-slices, skews lane i
// by 1+i cycles into the array and closes each tile on the per-row dones.
module systolic_skew_feeder #(
    parameter int LANES   = systolic_skew_feeder_pkg::LANES,
    parameter int DATA_W  = systolic_skew_feeder_pkg::DATA_W,
    parameter int KCNT_W  = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [LANES*DATA_W-1:0] s_act,
    input  logic [LANES*DATA_W-1:0] s_wgt,
    input  logic                    s_last,
    output logic                    arr_en,
    output logic [LANES*DATA_W-1:0] arr_act,
    output logic [LANES*DATA_W-1:0] arr_wgt,
    output logic [LANES-1:0]        arr_done,
    input  logic [LANES-1:0]        arr_out_dones,
    output logic                    busy,
    output logic                    tile_done,
    output logic [KCNT_W-1:0]       k_count,
    output logic                    timeout_err
);
    import systolic_skew_feeder_pkg::*;

    localparam int FLUSH_W = (LANES > 2) ? $clog2(LANES) : 1;
    localparam int WAIT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(LANES - 2);
    localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(TIMEOUT - 1);
    localparam int BW = 2 * DATA_W + 1;

    state_t             state, state_n;
    logic               xfer;
    logic               timeout_hit;
    logic [FLUSH_W-1:0] flush_cnt;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [LANES-1:0]   seen, seen_n;
    logic               ready_q;
    logic               en_q;

    // Handshake: a beat moves exactly on a cycle where s_valid && s_ready;
    // s_valid may rise at any time and the beat is held until accepted.
    assign s_ready = ready_q;
    assign xfer    = s_valid & ready_q;
    assign seen_n  = seen | arr_out_dones;
    assign busy    = (state != IDLE);
    assign arr_en  = en_q;

    always_comb begin
        state_n     = state;
        tile_done   = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (xfer) state_n = s_last ? FLUSH : STREAM;
            end
            STREAM: begin
                if (xfer && s_last) state_n = FLUSH;
            end
            FLUSH: begin
                if (flush_cnt == FLUSH_LAST) state_n = WAIT_DONE;
            end
            WAIT_DONE: begin
                // Completion in the same cycle as the timeout wins.
                if (&seen_n) begin
                    tile_done = 1'b1;
                    state_n   = IDLE;
                end else if (wait_cnt == WAIT_LAST) begin
                    timeout_hit = 1'b1;
                    state_n     = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ready_q     <= 1'b0;
            en_q        <= 1'b0;
            k_count     <= '0;
            flush_cnt   <= '0;
            wait_cnt    <= '0;
            seen        <= '0;
            timeout_err <= 1'b0;
        end else begin
            state     <= state_n;
            ready_q   <= (state_n == IDLE) || (state_n == STREAM);
            en_q      <= (state_n != IDLE);
            flush_cnt <= (state == FLUSH) ? flush_cnt + FLUSH_W'(1) : '0;
            wait_cnt  <= (state == WAIT_DONE) ? wait_cnt + WAIT_W'(1) : '0;
            seen      <= (state == WAIT_DONE) ? seen_n : '0;
            if (timeout_hit) timeout_err <= 1'b1;
            if (xfer) begin
                if (state == IDLE) begin
                    k_count <= KCNT_W'(1);
                end else if (k_count != '1) begin
                    k_count <= k_count + KCNT_W'(1);
                end
            end
        end
    end

    // Non-transfer cycles feed zeros, so bubbles leave the array sums alone.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        localparam int LO = lane_lo(i, DATA_W);
        logic [BW-1:0] lane_in;
        logic [BW-1:0] lane_out;

        assign lane_in = xfer ? {s_last, s_wgt[LO +: DATA_W], s_act[LO +: DATA_W]} : '0;

        skew_delay_line #(
            .DEPTH (i + 1),
            .W     (BW)
        ) u_skew (
            .clk   (clk),
            .rst_n (rst_n),
            .din   (lane_in),
            .dout  (lane_out)
        );

        assign arr_act[LO +: DATA_W] = lane_out[DATA_W-1:0];
        assign arr_wgt[LO +: DATA_W] = lane_out[2*DATA_W-1:DATA_W];
        assign arr_done[i]           = lane_out[BW-1];
    end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Bench for systolic_skew_feeder: directed tile scenarios with random data,
// bubbles and done patterns, checked cycle by cycle against a timeline model.
module tb_systolic_skew_feeder;
    import systolic_skew_feeder_pkg::*;

    localparam int KCNT_W  = 16;
    localparam int TIMEOUT = 64;
    localparam int RING    = 32;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    s_valid = 1'b0;
    logic                    s_ready;
    logic [LANES*DATA_W-1:0] s_act = '0;
    logic [LANES*DATA_W-1:0] s_wgt = '0;
    logic                    s_last = 1'b0;
    logic                    arr_en;
    logic [LANES*DATA_W-1:0] arr_act;
    logic [LANES*DATA_W-1:0] arr_wgt;
    logic [LANES-1:0]        arr_done;
    logic [LANES-1:0]        arr_out_dones = '0;
    logic                    busy;
    logic                    tile_done;
    logic [KCNT_W-1:0]       k_count;
    logic                    timeout_err;

    systolic_skew_feeder #(
        .LANES   (LANES),
        .DATA_W  (DATA_W),
        .KCNT_W  (KCNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_act         (s_act),
        .s_wgt         (s_wgt),
        .s_last        (s_last),
        .arr_en        (arr_en),
        .arr_act       (arr_act),
        .arr_wgt       (arr_wgt),
        .arr_done      (arr_done),
        .arr_out_dones (arr_out_dones),
        .busy          (busy),
        .tile_done     (tile_done),
        .k_count       (k_count),
        .timeout_err   (timeout_err)
    );

    // ---------------- clock ----------------
    initial forever #5 clk = ~clk;

    // ---------------- model state ----------------
    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;
    int data_mode = 0;

    // Lane-i value expected in absolute cycle t lives at [i][t % RING].
    logic [DATA_W-1:0] ring_act  [LANES][RING];
    logic [DATA_W-1:0] ring_wgt  [LANES][RING];
    logic              ring_done [LANES][RING];

    logic              exp_ready, exp_busy, exp_en, exp_tile_done, exp_terr;
    logic [KCNT_W-1:0] exp_kcount;
    logic [KCNT_W-1:0] kc;
    logic [KCNT_W-1:0] exp_q[$];

    function automatic void chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    endfunction

    function automatic void clear_ring();
        for (int i = 0; i < LANES; i++) begin
            for (int s = 0; s < RING; s++) begin
                ring_act[i][s]  = '0;
                ring_wgt[i][s]  = '0;
                ring_done[i][s] = 1'b0;
            end
        end
    endfunction

    // ---------------- driver tasks ----------------
    task automatic noise_inputs(input bit allow_valid);
        s_valid = allow_valid ? 1'($urandom_range(0, 1)) : 1'b0;
        s_last  = 1'($urandom_range(0, 1));
        for (int i = 0; i < LANES; i++) begin
            s_act[i*DATA_W +: DATA_W] = DATA_W'($urandom);
            s_wgt[i*DATA_W +: DATA_W] = DATA_W'($urandom);
        end
    endtask

    task automatic drive_beat(input int k, input bit last);
        s_valid = 1'b1;
        s_last  = last;
        for (int i = 0; i < LANES; i++) begin
            case (data_mode)
                1: begin
                    s_act[i*DATA_W +: DATA_W] = DATA_W'(i + 1);
                    s_wgt[i*DATA_W +: DATA_W] = DATA_W'(16'h10 + i);
                end
                2: begin
                    s_act[i*DATA_W +: DATA_W] = DATA_W'(k + 1);
                    s_wgt[i*DATA_W +: DATA_W] = DATA_W'(16'h100 + k + 1);
                end
                default: begin
                    s_act[i*DATA_W +: DATA_W] = DATA_W'($urandom);
                    s_wgt[i*DATA_W +: DATA_W] = DATA_W'($urandom);
                end
            endcase
        end
    endtask

    function automatic logic [LANES-1:0] done_pattern(input int mode, input int w);
        logic [LANES-1:0] one;
        one = LANES'(1);
        case (mode)
            0:       return (w >= 2) ? '1 : '0;
            1:       return (w < LANES) ? (one << w) : '0;
            2:       return LANES'(8'h7F);
            3:       return LANES'($urandom & $urandom);
            default: return (w == TIMEOUT - 1) ? '1 : '0;
        endcase
    endfunction

    // Checks the current cycle (inputs already applied), records any beat the
    // model says is accepted, then advances to the next cycle.
    task automatic tick();
        int slot;
        int idx;
        slot = cyc % RING;
        #1;
        for (int i = 0; i < LANES; i++) begin
            chk("arr_act", 32'(arr_act[i*DATA_W +: DATA_W]), 32'(ring_act[i][slot]));
            chk("arr_wgt", 32'(arr_wgt[i*DATA_W +: DATA_W]), 32'(ring_wgt[i][slot]));
            chk("arr_done", 32'(arr_done[i]), 32'(ring_done[i][slot]));
            ring_act[i][slot]  = '0;
            ring_wgt[i][slot]  = '0;
            ring_done[i][slot] = 1'b0;
        end
        chk("s_ready", 32'(s_ready), 32'(exp_ready));
        chk("busy", 32'(busy), 32'(exp_busy));
        chk("arr_en", 32'(arr_en), 32'(exp_en));
        chk("tile_done", 32'(tile_done), 32'(exp_tile_done));
        chk("k_count", 32'(k_count), 32'(exp_kcount));
        chk("timeout_err", 32'(timeout_err), 32'(exp_terr));
        if (s_valid && exp_ready) begin
            for (int i = 0; i < LANES; i++) begin
                idx = (cyc + 1 + i) % RING;
                ring_act[i][idx]  = s_act[i*DATA_W +: DATA_W];
                ring_wgt[i][idx]  = s_wgt[i*DATA_W +: DATA_W];
                ring_done[i][idx] = s_last;
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_tile(input int nbeats, input int bubble_pct, input int done_mode);
        logic [LANES-1:0] seen;
        logic [LANES-1:0] d;
        bit               finished;
        repeat ($urandom_range(0, 2)) begin
            noise_inputs(1'b0);
            tick();
        end
        exp_q.push_back(KCNT_W'(nbeats));
        for (int k = 0; k < nbeats; k++) begin
            if (k > 0 && $urandom_range(0, 99) < bubble_pct) begin
                noise_inputs(1'b0);
                tick();
            end
            drive_beat(k, k == nbeats - 1);
            tick();
            kc         = (k == 0) ? KCNT_W'(1) : ((kc == '1) ? kc : kc + KCNT_W'(1));
            exp_kcount = kc;
            exp_busy   = 1'b1;
            exp_en     = 1'b1;
            if (k == nbeats - 1) exp_ready = 1'b0;
        end
        // Zeros drain through the skew lines before completion is watched.
        repeat (LANES - 1) begin
            noise_inputs(1'b1);
            tick();
        end
        seen     = '0;
        finished = 1'b0;
        for (int w = 0; w < TIMEOUT && !finished; w++) begin
            noise_inputs(1'b1);
            d             = done_pattern(done_mode, w);
            arr_out_dones = d;
            exp_tile_done = ((seen | d) == '1);
            tick();
            seen = seen | d;
            if (exp_tile_done) begin
                finished = 1'b1;
            end else if (w == TIMEOUT - 1) begin
                finished = 1'b1;
                exp_terr = 1'b1;
            end
        end
        arr_out_dones = '0;
        exp_tile_done = 1'b0;
        exp_busy      = 1'b0;
        exp_en        = 1'b0;
        exp_ready     = 1'b1;
        noise_inputs(1'b0);
        chk("k_count_tile", 32'(k_count), 32'(exp_q.pop_front()));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_s_ready"}, 32'(s_ready), 32'd0);
        chk({tag, "_arr_en"}, 32'(arr_en), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_tile_done"}, 32'(tile_done), 32'd0);
        chk({tag, "_k_count"}, 32'(k_count), 32'd0);
        chk({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
        chk({tag, "_arr_done"}, 32'(arr_done), 32'd0);
        for (int i = 0; i < LANES; i++) begin
            chk({tag, "_arr_act"}, 32'(arr_act[i*DATA_W +: DATA_W]), 32'd0);
            chk({tag, "_arr_wgt"}, 32'(arr_wgt[i*DATA_W +: DATA_W]), 32'd0);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        clear_ring();
        exp_ready = 1'b0; exp_busy = 1'b0; exp_en = 1'b0;
        exp_tile_done = 1'b0; exp_terr = 1'b0; exp_kcount = '0; kc = '0;

        // reset state
        repeat (2) @(negedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready_before_edge", 32'(s_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        exp_ready = 1'b1;

        // single-beat tile, known lane values
        data_mode = 1;
        run_tile(1, 0, 0);

        // three back-to-back beats, lane value = beat index + 1
        data_mode = 2;
        run_tile(3, 0, 0);

        // beat, bubble, beat+last
        data_mode = 0;
        run_tile(2, 100, 0);

        // staggered per-row dones
        run_tile(4, 30, 1);

        // timeout, then the next tile must still be accepted
        run_tile(2, 0, 2);
        run_tile(5, 40, 0);

        // completion on the last allowed cycle wins over the timeout
        run_tile(3, 20, 4);

        // random done bits, random tile sizes
        for (int t = 0; t < 4; t++) begin
            run_tile($urandom_range(1, 10), 25, 3);
        end

        // reset in the middle of streaming
        noise_inputs(1'b0);
        tick();
        drive_beat(0, 1'b0);
        tick();
        kc = KCNT_W'(1); exp_kcount = kc; exp_busy = 1'b1; exp_en = 1'b1;
        drive_beat(1, 1'b0);
        tick();
        kc = KCNT_W'(2); exp_kcount = kc;
        noise_inputs(1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        clear_ring();
        kc = '0; exp_kcount = '0; exp_terr = 1'b0;
        exp_busy = 1'b0; exp_en = 1'b0; exp_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        exp_ready = 1'b1;
        run_tile(2, 0, 0);
        run_tile(1, 0, 1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
